// File: rtl/line_span_writer.sv
// Span-to-block write generator for the line buffer's updated-flag store.
// It also owns the three-bank update_switch rotation that advances on every line_start.
module line_span_writer #(
  parameter int LINE_WIDTH   = 640,
  parameter int BLOCK_ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9:0]              cmd_x,
  input  logic [9:0]              cmd_len,
  input  logic [7:0]              cmd_color,
  output logic [1:0]              update_switch,
  output logic [BLOCK_ADDR_W-1:0] pixel_addr,
  output logic                    write_pixel,
  output logic [3:0]              pixel_write_updated,
  output logic [7:0]              pixel_color,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_WRITE = 1'b1;
  localparam logic [10:0] LINE_END = 11'(LINE_WIDTH);

  logic [0:0]              state_q, state_d;
  logic [10:0]             cur_q, cur_d;
  logic [10:0]             end_q, end_d;
  logic [7:0]              color_q, color_d;
  logic [1:0]              switch_q, switch_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [3:0]              mask_q, mask_d;
  logic [7:0]              pcol_q, pcol_d;
  logic                    ovr_q, ovr_d;

  logic [10:0] cmd_sum, cmd_end;
  logic        cmd_ok, accept;
  logic [10:0] src_cur, src_end, blk_base, next_cur;
  logic [3:0]  src_mask;

  // 11-bit sum so an overflowing x+len still clips cleanly to the line end.
  assign cmd_sum = {1'b0, cmd_x} + {1'b0, cmd_len};
  assign cmd_end = (cmd_sum > LINE_END) ? LINE_END : cmd_sum;
  assign cmd_ok  = (cmd_len != 10'd0) && ({1'b0, cmd_x} < LINE_END);

  assign cmd_ready = (state_q == ST_IDLE) && !line_start && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // The first block is built straight from the command so it appears the cycle after accept.
  assign src_cur  = (state_q == ST_IDLE) ? {1'b0, cmd_x} : cur_q;
  assign src_end  = (state_q == ST_IDLE) ? cmd_end : end_q;
  assign blk_base = {src_cur[10:2], 2'b00};
  assign next_cur = blk_base + 11'd4;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign src_mask[gi] = ((blk_base + 11'(gi)) >= src_cur) &&
                            ((blk_base + 11'(gi)) < src_end);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    color_d  = color_q;
    switch_d = switch_q;
    addr_d   = addr_q;
    wr_d     = 1'b0;
    mask_d   = 4'd0;
    pcol_d   = pcol_q;
    ovr_d    = 1'b0;
    if (line_start) begin
      switch_d = (switch_q == 2'd2) ? 2'd0 : switch_q + 2'd1;
      ovr_d    = (state_q == ST_WRITE);
      state_d  = ST_IDLE;
    end else if (state_q == ST_WRITE) begin
      if (cur_q >= end_q) begin
        state_d = ST_IDLE;
      end else begin
        wr_d   = 1'b1;
        addr_d = src_cur[BLOCK_ADDR_W+1:2];
        mask_d = src_mask;
        pcol_d = color_q;
        cur_d  = next_cur;
      end
    end else if (accept && cmd_ok) begin
      state_d = ST_WRITE;
      end_d   = cmd_end;
      color_d = cmd_color;
      wr_d    = 1'b1;
      addr_d  = src_cur[BLOCK_ADDR_W+1:2];
      mask_d  = src_mask;
      pcol_d  = cmd_color;
      cur_d   = next_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      end_q    <= '0;
      color_q  <= '0;
      switch_q <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      mask_q   <= '0;
      pcol_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      color_q  <= color_d;
      switch_q <= switch_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      mask_q   <= mask_d;
      pcol_q   <= pcol_d;
      ovr_q    <= ovr_d;
    end
  end

  assign update_switch       = switch_q;
  assign pixel_addr          = addr_q;
  assign write_pixel         = wr_q;
  assign pixel_write_updated = mask_q;
  assign pixel_color         = pcol_q;
  assign busy                = (state_q == ST_WRITE);
  assign overrun             = ovr_q;

endmodule

// File: tb/tb_line_span_writer.sv
// Bench for line_span_writer: directed scenarios then random traffic, all checked against
// a queue-of-expected-block-writes reference model.
module tb_line_span_writer;

  logic       clk = 1'b0;
  logic       reset, line_start, cmd_valid, cmd_ready;
  logic [9:0] cmd_x, cmd_len;
  logic [7:0] cmd_color, pixel_color;
  logic [1:0] update_switch;
  logic [7:0] pixel_addr;
  logic       write_pixel, busy, overrun;
  logic [3:0] pixel_write_updated;

  always #5 clk = ~clk;

  line_span_writer #(.LINE_WIDTH(640), .BLOCK_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .line_start(line_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_len(cmd_len), .cmd_color(cmd_color),
    .update_switch(update_switch), .pixel_addr(pixel_addr),
    .write_pixel(write_pixel), .pixel_write_updated(pixel_write_updated),
    .pixel_color(pixel_color), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    int         addr;
    logic [3:0] mask;
    logic [7:0] col;
  } wr_t;

  wr_t wq[$];
  int  m_switch = 0;
  bit  m_ovr = 0;
  bit  m_after_rst = 0;
  bit  chk_en = 0;
  int  errors = 0;
  int  checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected block writes for a span, straight from the pixel-range rule.
  task automatic push_span(input int x, input int len, input logic [7:0] col);
    int  e;
    wr_t w;
    if (len == 0 || x >= 640) return;
    e = x + len;
    if (e > 640) e = 640;
    for (int b = x / 4; b <= (e - 1) / 4; b++) begin
      w.addr = b;
      w.col  = col;
      w.mask = 4'd0;
      for (int i = 0; i < 4; i++)
        if (b * 4 + i >= x && b * 4 + i < e) w.mask[i] = 1'b1;
      wq.push_back(w);
    end
  endtask

  task automatic step(input logic rst, input logic ls, input logic v,
                      input logic [9:0] x, input logic [9:0] len, input logic [7:0] col);
    bit exp_ready;
    @(negedge clk);
    reset = rst; line_start = ls; cmd_valid = v;
    cmd_x = x; cmd_len = len; cmd_color = col;
    #1;
    exp_ready = (wq.size() == 0) && !ls && !rst;
    if (chk_en) begin
      check_eq("cmd_ready", cmd_ready, exp_ready);
      check_eq("write_pixel", write_pixel, wq.size() != 0);
      check_eq("busy", busy, wq.size() != 0);
      check_eq("overrun", overrun, m_ovr);
      check_eq("update_switch", update_switch, m_switch);
      if (wq.size() != 0) begin
        check_eq("pixel_addr", pixel_addr, wq[0].addr);
        check_eq("mask", pixel_write_updated, wq[0].mask);
        check_eq("pixel_color", pixel_color, wq[0].col);
      end
      if (m_after_rst) begin
        check_eq("rst_addr", pixel_addr, 0);
        check_eq("rst_mask", pixel_write_updated, 0);
        check_eq("rst_color", pixel_color, 0);
      end
    end
    @(posedge clk);
    if (rst) begin
      wq.delete();
      m_switch = 0;
      m_ovr = 0;
      m_after_rst = 1;
      chk_en = 1;
    end else begin
      m_after_rst = 0;
      m_ovr = 0;
      if (ls) begin
        m_ovr = (wq.size() != 0);
        wq.delete();
        m_switch = (m_switch + 1) % 3;
      end else if (wq.size() != 0) begin
        void'(wq.pop_front());
      end else if (v) begin
        $display("accept x=%0d len=%0d color=%0h", x, len, col);
        push_span(int'(x), int'(len), col);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
  endtask

  task automatic span(input int x, input int len, input logic [7:0] col);
    step(1'b0, 1'b0, 1'b1, 10'(x), 10'(len), col);
  endtask

  initial begin
    logic       r_rst, r_ls, r_v;
    logic [9:0] r_x, r_len;
    step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
    idle(2);

    span(5, 2, 8'hA5);     idle(3);
    span(6, 7, 8'h3C);     idle(5);
    span(636, 20, 8'h11);  idle(3);
    span(640, 5, 8'h22);   idle(2);
    span(10, 0, 8'h33);    idle(2);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0);
      idle(1);
    end

    // Abort on the second write cycle of a long span.
    span(0, 40, 8'h77);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0);
    idle(3);

    // Reset in the middle of a span, then a fresh span.
    span(0, 40, 8'h55);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
    span(8, 4, 8'h99);
    idle(3);

    for (int c = 0; c < 600; c++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_ls  = ($urandom_range(0, 24) == 0);
      r_v   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) r_x = 10'($urandom_range(600, 1023));
      else                           r_x = 10'($urandom_range(0, 639));
      if ($urandom_range(0, 3) == 0) r_len = 10'($urandom_range(0, 1023));
      else                           r_len = 10'($urandom_range(0, 24));
      step(r_rst, r_ls, r_v, r_x, r_len, 8'($urandom_range(0, 255)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_span_writer.md
# line_span_writer

Draw-side producer for the GPU line buffer's per-pixel updated-flag store. It accepts horizontal span commands (start x, length, colour) over a valid/ready handshake. Each span is converted into a sequence of 4-pixel block writes carrying a per-pixel update mask. The block also owns the three-way `update_switch` rotation that selects which flag bank is being updated, read and cleared on each scanline.

## Interface
Parameters:
- `LINE_WIDTH`, 640: visible pixels per line. Must be a multiple of 4.
- `BLOCK_ADDR_W`, 8: block address width, which is `LINE_WIDTH/4` entries.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `line_start`  in  1  one-cycle pulse at the start of each scanline.
- `cmd_valid`  in  1  span command valid.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_x`  in  10  first pixel of the span.
- `cmd_len`  in  10  span length in pixels.
- `cmd_color`  in  8  span colour.
- `update_switch`  out  2  bank rotation state, range 0..2.
- `pixel_addr`  out  8  block address, which is x[9:2].
- `write_pixel`  out  1  block write strobe.
- `pixel_write_updated`  out  4  per-pixel mask. Bit i corresponds to x[1:0]==i.
- `pixel_color`  out  8  colour for the masked pixels.
- `busy`  out  1  a span is being emitted.
- `overrun`  out  1  one-cycle pulse when a span is aborted by `line_start`.

## Operation
- States are IDLE and WRITE.
- `cmd_ready` = (state==IDLE) && !`line_start` && !`reset`.
- A command is accepted when `cmd_valid` && `cmd_ready`. On accept, latch `cur`=`cmd_x`, `end`=min(`cmd_x`+`cmd_len`, `LINE_WIDTH`) computed at 11 bits, and the colour.
  - If `cmd_len`==0 or `cmd_x`>=`LINE_WIDTH`, the command is consumed and discarded. The block stays in IDLE and issues no write.
  - Otherwise the block goes to WRITE.
- WRITE, one block per cycle:
  - `pixel_addr`=`cur`[9:2].
  - Mask bit i=1 iff the pixel at `cur`[9:2]*4+i satisfies `cur` <= pixel < `end`.
  - `write_pixel`=1 and `pixel_color` = latched colour.
  - Next `cur` = (`cur`[9:2]+1)*4. If next `cur` >= `end`, the block returns to IDLE.
- A span emits exactly (`end`-1)/4 - `cur`/4 + 1 writes, using integer division on the original `cur` and `end`.
- `busy` = (state==WRITE).
- `update_switch` advances 0→1→2→0 on each `line_start`. The value 3 never occurs.
- `line_start` takes priority over everything else:
  - If it arrives in WRITE, the span is abandoned, the block returns to IDLE, and `overrun` pulses in the following cycle.
  - `cmd_ready` is low in the `line_start` cycle, so a command cannot be accepted in the same cycle.
- The downstream flag store ORs the mask into the existing flags. This block never issues an all-zero mask while `write_pixel`=1.

## Timing
- All outputs except `cmd_ready` are registered.
- Latency:
  - Accept at cycle N gives the first `write_pixel` at N+1.
  - Consecutive blocks of a span go out on consecutive cycles with no gaps.
  - After the last write, `cmd_ready` is high in the next cycle, so there is one bubble between back-to-back spans.
- A `line_start` at cycle N gives `update_switch` updated at N+1.
  - If the block was in WRITE at N, `write_pixel`=0 from N+1 and `overrun`=1 for cycle N+1 only.
  - The write issued at N completes normally.
- Reset values:
  - `update_switch`=0, `write_pixel`=0, `pixel_write_updated`=0, `pixel_addr`=0, `pixel_color`=0, `busy`=0, `overrun`=0.
  - `cmd_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Reset mid-span drops the span with no `overrun` pulse.
- Wrap-around:
  - `end` is clipped at `LINE_WIDTH`, so addresses never exceed `LINE_WIDTH`/4-1.
  - `cmd_x`+`cmd_len` overflowing 10 bits is handled by the 11-bit sum followed by the clip.

## Test plan
- Span x=5, len=2: one write at accept+1 with addr=1, mask=4'b0110, colour echoed. `cmd_ready` is high at accept+2.
- Span x=6, len=7: three consecutive writes.
  - addr 1, mask 4'b1100.
  - addr 2, mask 4'b1111.
  - addr 3, mask 4'b0001.
- Clipping:
  - x=636, len=20: one write, addr=159, mask 4'b1111.
  - x=640, len=5: accepted, no write issued.
  - len=0: accepted, no write issued.
- Rotation: four `line_start` pulses with no commands give `update_switch` 1, 2, 0, 1. `write_pixel` stays 0 throughout.
- Abort: span x=0, len=40 with `line_start` asserted on its second write cycle.
  - Exactly 2 writes (addr 0, 1).
  - `overrun`=1 for one cycle.
  - `update_switch` incremented.
  - `cmd_ready` high the cycle after.
- Reset mid-span: `reset` asserted during WRITE.
  - All outputs reach their reset values the next cycle, with no `overrun`.
  - A new span x=8, len=4 afterwards gives a single write, addr 2, mask 4'b1111.
